// File: rtl/len_sched.sv
// len_sched: round-robin scheduler that shares one bit-length unit among N_REQ requesters.
module len_sched #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DW        = 64,
    parameter int unsigned LW        = 8,
    parameter int unsigned TO_CYCLES = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_num,
    output logic [N_REQ-1:0]    ack,
    output logic [LW-1:0]       resp_len,
    output logic                resp_err,
    output logic                busy,
    output logic                md_start,
    output logic [DW-1:0]       md_num,
    input  logic [LW-1:0]       md_len,
    input  logic                md_end
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    rr_ptr_d;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_d;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    scan_idx;
    logic             gnt_vld;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_d;
    logic             to_hit;
    logic [DW-1:0]    opnd_d;
    logic [N_REQ-1:0] ack_d;
    logic [LW-1:0]    resp_len_d;
    logic             resp_err_d;
    logic             busy_d;
    logic             md_start_d;
    logic [DW-1:0]    num_arr [N_REQ];

    // The unit has had TO_CYCLES WAIT cycles once this cycle also passes without md_end
    assign to_hit = (cnt == TO_LAST);

    // Split the flat operand bus into per-requester words
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            num_arr[i] = req_num[i*DW +: DW];
        end
    end

    // Round-robin pick: first pending requester at or after rr_ptr
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = IW'((32'(rr_ptr) + i) % N_REQ);
            if (!gnt_vld && req[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; md_end only matters in WAIT, where it beats the timeout
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (gnt_vld) next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  if (md_end || to_hit) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Next values for the output and datapath registers
    always_comb begin
        ack_d      = '0;
        resp_len_d = '0;
        resp_err_d = 1'b0;
        busy_d     = (next_state != S_IDLE);
        md_start_d = (next_state == S_ISSUE);
        idx_d      = idx;
        opnd_d     = md_num;
        rr_ptr_d   = rr_ptr;
        cnt_d      = cnt;
        case (state)
            S_IDLE: begin
                if (gnt_vld) begin
                    idx_d  = gnt_idx;
                    opnd_d = num_arr[gnt_idx];
                end
            end
            S_ISSUE: begin
                cnt_d = '0;
            end
            S_WAIT: begin
                if (md_end) begin
                    resp_len_d = md_len;
                end else begin
                    cnt_d = cnt + CW'(1);
                    if (to_hit) resp_err_d = 1'b1;
                end
                if (next_state == S_RESP) ack_d = N_REQ'(1) << idx;
            end
            S_RESP: begin
                if (idx == IW'(N_REQ - 1)) rr_ptr_d = '0;
                else                       rr_ptr_d = idx + IW'(1);
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ack      <= '0;
            resp_len <= '0;
            resp_err <= 1'b0;
            busy     <= 1'b0;
            md_start <= 1'b0;
            md_num   <= '0;
            idx      <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            ack      <= ack_d;
            resp_len <= resp_len_d;
            resp_err <= resp_err_d;
            busy     <= busy_d;
            md_start <= md_start_d;
            md_num   <= opnd_d;
            idx      <= idx_d;
            rr_ptr   <= rr_ptr_d;
            cnt      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_len_sched.sv
// tb_len_sched: table-driven and scoreboard checks for len_sched with a behavioural length unit.
module tb_len_sched;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned DW    = 64;
    localparam int unsigned LW    = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_num;
    logic [N_REQ-1:0]    ack;
    logic [LW-1:0]       resp_len;
    logic                resp_err;
    logic                busy;
    logic                md_start;
    logic [DW-1:0]       md_num;
    logic [LW-1:0]       md_len = '0;
    logic                md_end = 1'b0;

    typedef struct {
        logic [N_REQ-1:0] ack;
        logic [LW-1:0]    len;
        logic             err;
    } exp_t;

    typedef struct {
        int               who;
        logic [DW-1:0]    num;
        logic [N_REQ-1:0] exp_ack;
        logic [LW-1:0]    exp_len;
    } vec_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    vec_t          vecs[8];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            c0;
    int            at;
    int            prev_at;
    logic          unit_en   = 1'b1;
    logic          force_end = 1'b0;
    logic          pend      = 1'b0;
    logic [LW-1:0] pend_len  = '0;

    len_sched #(.N_REQ(N_REQ), .DW(DW), .LW(LW), .TO_CYCLES(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_num  (req_num),
        .ack      (ack),
        .resp_len (resp_len),
        .resp_err (resp_err),
        .busy     (busy),
        .md_start (md_start),
        .md_num   (md_num),
        .md_len   (md_len),
        .md_end   (md_end)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LW-1:0] bitlen(input logic [DW-1:0] v);
        logic [LW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(DW); i++) begin
            if (v[i]) r = LW'(i + 1);
        end
        return r;
    endfunction

    // Behavioural length unit: md_end one cycle after md_start when enabled
    always @(negedge clk) begin
        md_end   = pend | force_end;
        md_len   = pend ? pend_len : '0;
        pend     = unit_en & md_start;
        pend_len = bitlen(md_num);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [N_REQ-1:0] a, input logic [LW-1:0] l, input logic e);
        exp_t x;
        x.ack = a;
        x.len = l;
        x.err = e;
        sb_q.push_back(x);
    endtask

    task automatic wait_ack(input string name, input int budget, output int seen);
        seen = -1;
        for (int k = 0; k < budget && seen < 0; k++) begin
            @(negedge clk);
            if (ack !== '0) seen = cyc;
        end
        if (seen < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no ack within %0d cycles", name, budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard: every ack pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (ack !== '0) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack=%b, want no ack", ack);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_ack", 64'(ack), 64'(mon_e.ack));
                check("sb_resp_len", 64'(resp_len), 64'(mon_e.len));
                check("sb_resp_err", 64'(resp_err), 64'(mon_e.err));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 64'h0,                   4'b0010, 8'd0};
        vecs[1] = '{1, 64'h8000_0000_0000_0000, 4'b0010, 8'd64};
        vecs[2] = '{1, 64'h1,                   4'b0010, 8'd1};
        vecs[3] = '{2, 64'hFF,                  4'b0100, 8'd8};
        vecs[4] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 8'd64};
        vecs[5] = '{0, 64'h0000_0001_0000_0000, 4'b0001, 8'd33};
        vecs[6] = '{3, 64'h2,                   4'b1000, 8'd2};
        vecs[7] = '{2, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0100, 8'd63};

        rst     = 1'b1;
        req     = '0;
        req_num = '0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_ack", 64'(ack), 64'h0);
        check("rst_resp_len", 64'(resp_len), 64'h0);
        check("rst_resp_err", 64'(resp_err), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_md_start", 64'(md_start), 64'h0);
        check("rst_md_num", 64'(md_num), 64'h0);
        rst = 1'b0;

        // Single request, cycle-by-cycle
        req_num[0 +: DW] = 64'h9;
        req[0] = 1'b1;
        push_exp(4'b0001, 8'd4, 1'b0);
        @(negedge clk);
        check("t1_md_start", 64'(md_start), 64'h1);
        check("t1_md_num", 64'(md_num), 64'h9);
        check("t1_busy_issue", 64'(busy), 64'h1);
        check("t1_no_ack_issue", 64'(ack), 64'h0);
        @(negedge clk);
        check("t1_md_start_wait", 64'(md_start), 64'h0);
        check("t1_busy_wait", 64'(busy), 64'h1);
        @(negedge clk);
        check("t1_ack", 64'(ack), 64'h1);
        check("t1_busy_resp", 64'(busy), 64'h1);
        req[0] = 1'b0;
        @(negedge clk);
        check("t1_busy_idle", 64'(busy), 64'h0);
        check("t1_ack_cleared", 64'(ack), 64'h0);

        // Table of single-requester operands including boundaries
        foreach (vecs[v]) begin
            @(negedge clk);
            req_num[vecs[v].who*DW +: DW] = vecs[v].num;
            req[vecs[v].who] = 1'b1;
            push_exp(vecs[v].exp_ack, vecs[v].exp_len, 1'b0);
            c0 = cyc;
            wait_ack("vec_ack", 10, at);
            check("vec_latency", 64'(at - c0), 64'd3);
            req[vecs[v].who] = 1'b0;
        end

        // All four requesters from reset: served 0,1,2,3 four cycles apart
        do_reset();
        req_num[0*DW +: DW] = 64'h3;
        req_num[1*DW +: DW] = 64'hF0;
        req_num[2*DW +: DW] = 64'h1_0000;
        req_num[3*DW +: DW] = 64'h4000_0000_0000_0000;
        req = 4'b1111;
        push_exp(4'b0001, 8'd2, 1'b0);
        push_exp(4'b0010, 8'd8, 1'b0);
        push_exp(4'b0100, 8'd17, 1'b0);
        push_exp(4'b1000, 8'd63, 1'b0);
        prev_at = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack("all4_ack", 12, at);
            if (k > 0) check("all4_spacing", 64'(at - prev_at), 64'd4);
            prev_at = at;
            req = req & ~ack;
        end

        // Requesters 0 and 2 held: grants alternate
        @(negedge clk);
        req_num[0*DW +: DW] = 64'h5;
        req_num[2*DW +: DW] = 64'h100;
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            push_exp(4'b0001, 8'd3, 1'b0);
            push_exp(4'b0100, 8'd9, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            wait_ack("alt_ack", 12, at);
        end
        req = '0;

        // Unit never completes: timeout after 15 WAIT cycles, then a normal one
        @(negedge clk);
        unit_en = 1'b0;
        req_num[0 +: DW] = 64'h9;
        req[0] = 1'b1;
        push_exp(4'b0001, 8'd0, 1'b1);
        c0 = cyc;
        wait_ack("to_ack", 40, at);
        check("to_latency", 64'(at - c0), 64'd17);
        req[0] = 1'b0;
        @(negedge clk);
        unit_en = 1'b1;
        req_num[0 +: DW] = 64'h20;
        req[0] = 1'b1;
        push_exp(4'b0001, 8'd6, 1'b0);
        c0 = cyc;
        wait_ack("after_to_ack", 10, at);
        check("after_to_latency", 64'(at - c0), 64'd3);
        req[0] = 1'b0;

        // Reset during WAIT abandons the operation
        @(negedge clk);
        unit_en = 1'b0;
        req_num[2*DW +: DW] = 64'h77;
        req[2] = 1'b1;
        @(negedge clk);
        check("rw_md_start", 64'(md_start), 64'h1);
        @(negedge clk);
        check("rw_busy_wait", 64'(busy), 64'h1);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("rw_busy", 64'(busy), 64'h0);
        check("rw_ack", 64'(ack), 64'h0);
        check("rw_md_start_off", 64'(md_start), 64'h0);
        check("rw_md_num", 64'(md_num), 64'h0);
        rst = 1'b0;
        @(posedge clk);
        force_end = 1'b1;
        @(posedge clk);
        force_end = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stray_end_busy", 64'(busy), 64'h0);
        end
        unit_en = 1'b1;
        req_num[0*DW +: DW] = 64'h1F;
        req_num[3*DW +: DW] = 64'h400;
        req = 4'b1001;
        push_exp(4'b0001, 8'd5, 1'b0);
        push_exp(4'b1000, 8'd11, 1'b0);
        for (int k = 0; k < 2; k++) begin
            wait_ack("post_rst_ack", 12, at);
            req = req & ~ack;
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/len_sched.md
Name: len_sched

Overview:
- Round-robin scheduler that shares one bit-length unit (md_start/num_in -> len_out/md_end handshake) among N_REQ requesters.
- Arbitration: selects a pending requester, latches its 64-bit operand, issues a single-cycle start to the unit and waits for completion.
- Completion: returns the length to the winning requester with a one-cycle ack. A timeout guards against a unit that never completes.
- Placement: between the requesting datapath blocks and the single shared length unit.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 64, operand width.
- LW, 8, length result width.
- TO_CYCLES, 15, max WAIT cycles before error (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester request level; held until matching ack.
- req_num  in  N_REQ*DW  operands; slice i = req_num[i*DW +: DW], stable while req[i]=1.
- ack  out  N_REQ  one-hot, one-cycle completion pulse.
- resp_len  out  LW  result, valid only in the ack cycle.
- resp_err  out  1  timeout flag, valid only in the ack cycle.
- busy  out  1  high in any state other than IDLE.
- md_start  out  1  start pulse to the shared length unit.
- md_num  out  DW  operand to the shared unit.
- md_len  in  LW  result from the shared unit.
- md_end  in  1  completion from the shared unit.

Behaviour:
- Reset: rst=1 at a clock edge forces the following values, with no pending ack.
  - state=IDLE, rr_ptr=0, latched index=0, latched operand=0, timeout count=0.
  - ack=0, resp_len=0, resp_err=0, busy=0, md_start=0, md_num=0.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs decode from registered state and registers; no input-to-output combinational path.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise grant the first set bit scanning rr_ptr, rr_ptr+1, ... (mod N_REQ). Latch the grant index and its operand, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - md_start=1 and md_num=latched operand.
  - Clear the timeout count; go to WAIT.
  - md_end seen in this cycle is ignored.
- WAIT (md_start=0):
  - If md_end=1: capture md_len into resp_len, set resp_err=0, go to RESP.
  - Else increment the count. When count reaches TO_CYCLES with no md_end: resp_len=0, resp_err=1, go to RESP.
  - If md_end arrives in the same cycle the count hits TO_CYCLES, md_end wins and resp_err=0.
- RESP (1 cycle):
  - ack[idx]=1, resp_len and resp_err driven.
  - rr_ptr <= (idx+1) mod N_REQ; go to IDLE.
  - Requests are not sampled in RESP.
- md_num holds the latched operand in all states; md_start is high only in ISSUE.
- Latency with a compliant unit (md_end the cycle after md_start):
  - req sampled in IDLE at cycle t; md_start at t+1; md_end at t+2; ack at t+3.
  - Back-to-back throughput: one operation per 4 cycles.
- Withdrawal: if a requester drops req mid-transaction, the operation still completes and its ack still pulses. The requester must ignore that ack.
- md_end in IDLE or RESP is ignored with no state change.
- Reset mid-transaction abandons the operation; no ack is produced for it.
- Fairness: continuously asserted requesters are each served within N_REQ transactions.

Test Plan:
1. Single request: req=0001, num0=0x9 -> md_start at t+1 with md_num=0x9; ack=0001 at t+3 with resp_len=4, resp_err=0; busy high t+1..t+3.
2. Boundary operands via requester 1:
   - num=0 -> resp_len=0, resp_err=0.
   - num=0x8000_0000_0000_0000 -> resp_len=64.
   - num=0x1 -> resp_len=1.
3. All four requesters asserted from reset -> acks in order 0001, 0010, 0100, 1000, spaced 4 cycles apart, each carrying its own length.
4. req[0] and req[2] held continuously -> grants alternate 0,2,0,2 over 8 transactions; requester 1 is never acked.
5. Stubbed unit with md_end tied 0 -> ack at the RESP cycle after 15 WAIT cycles with resp_err=1, resp_len=0. The next request then completes normally.
6. rst asserted during WAIT -> no ack, busy=0 on the next cycle. A later md_end is ignored. A new request proceeds from rr_ptr=0.
